// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory-access stage
//
// Contents:
//   MEM_ADDR_W / MEM_DATA_W / MEM_REG_W : default widths, also used by mem_wb_t
//   HALF_STEP                           : byte distance between the two halves of a word
//   mem_state_e                         : memory-access FSM states
//   mem_wb_t                            : fields handed to the writeback stage
package mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_REG_W  = 4;

    localparam int HALF_STEP = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LD_HI = 2'd1,
        ST_ST_HI = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [MEM_REG_W-1:0]  rd;
        logic [MEM_DATA_W-1:0] data_calc;
    } mem_wb_t;

endpackage

// File: rtl/memory_access_mem_wb_pipe_reg.sv
// rtl/memory_access_mem_wb_pipe_reg.sv - output register from memory access to writeback
//
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset (clears everything)
//   wb_d           : next writeback fields
//   hold_data      : keep rd / data_calc unchanged this cycle (flags still load)
//   misaligned_d   : next value of the misalignment error pulse
//   wb_q           : registered writeback fields
//   misaligned_q   : registered misalignment pulse
module mem_wb_pipe_reg
    import mem_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  mem_wb_t wb_d,
    input  logic    hold_data,
    input  logic    misaligned_d,
    output mem_wb_t wb_q,
    output logic    misaligned_q
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_q         <= '0;
            misaligned_q <= 1'b0;
        end else begin
            wb_q.mem_to_reg <= wb_d.mem_to_reg;
            wb_q.reg_write  <= wb_d.reg_write;
            misaligned_q    <= misaligned_d;
            if (!hold_data) begin
                wb_q.rd        <= wb_d.rd;
                wb_q.data_calc <= wb_d.data_calc;
            end
        end
    end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory-access stage driving a 16-bit synchronous data memory
//
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   valid_i                       : execute presents an instruction
//   mem_read_i / mem_write_i      : 32-bit load / store request (both set = load)
//   word_i                        : store size, 1 = 32-bit, 0 = 16-bit
//   addr_i, wdata_i, alu_result_i : effective address, store data, ALU result
//   rd_i, reg_write_i             : destination register and its write enable
//   stall_o                       : upstream must hold (second half in flight)
//   data_mem_*_o                  : address / write data / read and write enables
//   mem_to_reg_o, data_calc_o,
//   rd_o, reg_write_o             : registered writeback controls
//   misaligned_o                  : registered one-cycle error pulse
module memory_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int REG_W  = MEM_REG_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              word_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic              reg_write_i,
    output logic              stall_o,
    output logic [ADDR_W-1:0] data_mem_addr_o,
    output logic [15:0]       data_mem_wdata_o,
    output logic              data_mem_re_o,
    output logic              data_mem_we_o,
    output logic              mem_to_reg_o,
    output logic [DATA_W-1:0] data_calc_o,
    output logic [REG_W-1:0]  rd_o,
    output logic              reg_write_o,
    output logic              misaligned_o
);

    mem_state_e        state_q;
    logic [ADDR_W-1:0] addr_hi_q;
    logic [15:0]       wdata_hi_q;
    logic              reg_write_q;

    logic              accept;
    logic              mem_op;
    logic              misaligned;
    logic              take_ld;
    logic              take_st;
    logic [ADDR_W-1:0] addr_next;
    logic              re_raw;
    logic              we_raw;

    mem_wb_t           wb_d;
    mem_wb_t           wb_q;
    logic              hold_data;
    logic              misaligned_d;

    // Instructions are only looked at while idle; a second half ignores the inputs.
    assign accept     = valid_i && (state_q == ST_IDLE);
    assign mem_op     = mem_read_i || mem_write_i;
    assign misaligned = mem_op && addr_i[0];
    // A read request wins over a simultaneous write request.
    assign take_ld    = accept && mem_read_i && !addr_i[0];
    assign take_st    = accept && mem_write_i && !mem_read_i && !addr_i[0];
    assign addr_next  = addr_i + ADDR_W'(HALF_STEP);

    assign stall_o    = (state_q != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_hi_q   <= '0;
            wdata_hi_q  <= '0;
            reg_write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_ld) begin
                        state_q     <= ST_LD_HI;
                        addr_hi_q   <= addr_next;
                        reg_write_q <= reg_write_i;
                    end else if (take_st && word_i) begin
                        state_q    <= ST_ST_HI;
                        addr_hi_q  <= addr_next;
                        wdata_hi_q <= wdata_i[31:16];
                    end
                end
                ST_LD_HI: state_q <= ST_IDLE;
                ST_ST_HI: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Memory-side address/data/enable muxing.
    always_comb begin
        data_mem_addr_o  = addr_i;
        data_mem_wdata_o = wdata_i[15:0];
        re_raw           = 1'b0;
        we_raw           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                re_raw = take_ld;
                we_raw = take_st;
            end
            ST_LD_HI: begin
                data_mem_addr_o = addr_hi_q;
                re_raw          = 1'b1;
            end
            ST_ST_HI: begin
                data_mem_addr_o  = addr_hi_q;
                data_mem_wdata_o = wdata_hi_q;
                we_raw           = 1'b1;
            end
            default: begin
                re_raw = 1'b0;
                we_raw = 1'b0;
            end
        endcase
    end

    // Enables are gated by reset so an abandoned access never reaches memory.
    assign data_mem_re_o = re_raw && rst_ni;
    assign data_mem_we_o = we_raw && rst_ni;

    // Writeback sequencing: a load shows mem_to_reg for two cycles and commits
    // only on the second, when the high half arrives from memory.
    always_comb begin
        wb_d.mem_to_reg = 1'b0;
        wb_d.reg_write  = 1'b0;
        wb_d.rd         = rd_i;
        wb_d.data_calc  = alu_result_i;
        hold_data       = 1'b1;
        misaligned_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    hold_data = 1'b0;
                    if (misaligned) begin
                        misaligned_d = 1'b1;
                    end else if (mem_read_i) begin
                        wb_d.mem_to_reg = 1'b1;
                    end else if (!mem_write_i) begin
                        wb_d.reg_write = reg_write_i;
                    end
                end
            end
            ST_LD_HI: begin
                wb_d.mem_to_reg = 1'b1;
                wb_d.reg_write  = reg_write_q;
            end
            default: begin
                wb_d.mem_to_reg = 1'b0;
            end
        endcase
    end

    mem_wb_pipe_reg u_wb_reg (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wb_d         (wb_d),
        .hold_data    (hold_data),
        .misaligned_d (misaligned_d),
        .wb_q         (wb_q),
        .misaligned_q (misaligned_o)
    );

    assign mem_to_reg_o = wb_q.mem_to_reg;
    assign reg_write_o  = wb_q.reg_write;
    assign rd_o         = wb_q.rd;
    assign data_calc_o  = wb_q.data_calc;

endmodule
